floating_division_iter: RTL
===========================

FLOATING_DIVISION_ITER -- requirements
Module: floating_division_iter

Interface
REQ-001 The block SHALL have one parameter: ZERO_ON_UNDERFLOW, default 1, meaning 1 = underflow gives signed zero and 0 = underflow gives signed smallest normal (exp 1, mantissa 0).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request a division, sampled in IDLE only.
REQ-005 The block SHALL have port A, input, 32 bits: IEEE-754 single-precision dividend.
REQ-006 The block SHALL have port B, input, 32 bits: IEEE-754 single-precision divisor.
REQ-007 The block SHALL have port busy, output, 1 bit: high from the cycle after start is accepted through the cycle done is high.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking result valid.
REQ-009 The block SHALL have port result, output, 32 bits: quotient A/B.
REQ-010 The block SHALL have port div_by_zero, output, 1 bit: flag for the last completed operation.

Function
REQ-011 The FSM SHALL use states IDLE -> DIVIDE -> NORM -> DONE -> IDLE.
REQ-012 When start=1 in IDLE at edge N, A and B SHALL be registered; the inputs are not required to be held after edge N.
REQ-013 DIVIDE SHALL occupy exactly 25 cycles, producing one quotient bit per cycle by restoring division of {1,A[22:0]} by {1,B[22:0]}, giving q[24:0] where q[24] is the integer bit.
REQ-014 NORM SHALL take 1 cycle; done SHALL be high during cycle N+27; the state SHALL then return to IDLE.
REQ-015 Latency SHALL be fixed at 27 cycles for all operands, including special cases.
REQ-016 start while busy SHALL be ignored, with no queuing.
REQ-017 The next start SHALL be accepted in the cycle after done, giving a throughput of 1 op per 28 cycles.
REQ-018 Sign SHALL be A[31] XOR B[31] for all results except NaN.
REQ-019 Normalisation SHALL be: if q[24]=1, mantissa = q[23:1] and exp = eA - eB + 127; else mantissa = q[22:0] and exp = eA - eB + 126.
REQ-020 The exponent SHALL be computed in a signed width of at least 10 bits; rounding SHALL be truncation.
REQ-021 Overflow (exp >= 255) SHALL give a signed infinity (exp 255, mantissa 0).
REQ-022 Underflow (exp <= 0) SHALL give a result per ZERO_ON_UNDERFLOW.
REQ-023 An operand with exp field 0 SHALL be treated as zero (denormals flushed).
REQ-024 An operand with exp field 255 SHALL make result = 32'h7FC00000.
REQ-025 Precedence SHALL be: NaN rule > B zero > A zero > overflow/underflow.
REQ-026 B zero with A nonzero SHALL give a signed infinity and div_by_zero=1.
REQ-027 A zero with B zero SHALL give 32'h7FC00000 and div_by_zero=1.
REQ-028 A zero with B nonzero SHALL give a signed zero.
REQ-029 result and div_by_zero SHALL be updated only at entry to DONE.
REQ-030 result and div_by_zero SHALL hold their values until the next DONE or reset.

Reset
REQ-031 rst=1 at any edge SHALL force IDLE, busy=0, done=0, result=0, div_by_zero=0, and clear all datapath registers.
REQ-032 Reset mid-operation SHALL abort the operation, and no done SHALL follow.
REQ-033 rst SHALL have priority over start in the same cycle.

Structure
REQ-034 Shared package float_pkg SHALL hold the FSM state encoding and the constants EXP_BIAS=127, EXP_MAX=255, MANT_W=23, QNAN=32'h7FC00000.
REQ-035 One sub-module SHALL exist: float_unpack (combinational; splits a word into sign, exp, mantissa with the hidden bit, and the is_zero/is_special flags).
REQ-036 The divider core SHALL be a 25-bit remainder register, a 24-bit divisor register and a 5-bit iteration counter, counting down 24..0.

Verification
REQ-037 Scenario: A=0x40400000 (3.0), B=0x3FC00000 (1.5) -> result 0x40000000, done exactly 27 cycles after start, div_by_zero=0.
REQ-038 Scenario: A=0x3F800000 (1.0), B=0x40400000 (3.0) -> result 0x3EAAAAAA (truncated).
REQ-039 Scenario: A=0xC0CCCCCD (-6.4), B=0x3F000000 (0.5) -> result 0xC14CCCCD.
REQ-040 Scenario: A=0x3F800000, B=0x00000000 -> result 0x7F800000 and div_by_zero=1; then A=0, B=0 -> result 0x7FC00000.
REQ-041 Scenario: A=0x7F000000, B=0x00800000 -> result 0x7F800000 (overflow); A=0x00800000, B=0x7F000000 -> result 0x00000000 with ZERO_ON_UNDERFLOW=1.
REQ-042 Scenario: start, then rst at cycle 10 -> no done, outputs zero; start pulsed while busy -> ignored, exactly one done.

Source files
------------

// File: rtl/float_pkg.sv
// Shared types and constants for the iterative single-precision divider.
// Pure declarations; no logic, no latency, no flow control.
package float_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        NORM   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int          EXP_BIAS  = 127;
    localparam int          EXP_MAX   = 255;
    localparam int          MANT_W    = 23;
    localparam logic [31:0] QNAN      = 32'h7FC00000;
    localparam logic [4:0]  ITER_LAST = 5'd24;

endpackage

// File: rtl/float_unpack.sv
// Splits an IEEE-754 single into sign, exponent and mantissa with hidden bit.
// Combinational, zero latency; no flow control.
// Denormals are flushed: a zero exponent field reports is_zero and clears the hidden bit.
module float_unpack (
    input  logic [31:0] word,
    output logic        sign,
    output logic [7:0]  exp,
    output logic [23:0] mant,
    output logic        is_zero,
    output logic        is_special
);
    import float_pkg::*;

    assign sign       = word[31];
    assign exp        = word[30:23];
    assign is_zero    = (exp == 8'd0);
    assign is_special = (exp == 8'(EXP_MAX));
    assign mant       = {~is_zero, word[MANT_W-1:0]};

endmodule

// File: rtl/floating_division_iter.sv
// Iterative single-precision divider: restoring division, one quotient bit per cycle.
// Fixed latency: start accepted at edge N, done pulses in cycle N+27; one op per 28 cycles.
// No backpressure: start is only honoured in IDLE, requests while busy are dropped.
module floating_division_iter #(
    parameter bit ZERO_ON_UNDERFLOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        div_by_zero
);
    import float_pkg::*;

    localparam logic signed [9:0] BIAS_HI = 10'(EXP_BIAS);
    localparam logic signed [9:0] BIAS_LO = 10'(EXP_BIAS - 1);
    localparam logic signed [9:0] EXP_TOP = 10'(EXP_MAX);

    logic        a_sign, b_sign, a_zero, b_zero, a_special, b_special;
    logic [7:0]  a_exp, b_exp;
    logic [23:0] a_mant, b_mant;

    float_unpack u_unpack_a (
        .word       (A),
        .sign       (a_sign),
        .exp        (a_exp),
        .mant       (a_mant),
        .is_zero    (a_zero),
        .is_special (a_special)
    );

    float_unpack u_unpack_b (
        .word       (B),
        .sign       (b_sign),
        .exp        (b_exp),
        .mant       (b_mant),
        .is_zero    (b_zero),
        .is_special (b_special)
    );

    state_t            state;
    logic [24:0]       rem;
    logic [23:0]       dvsr;
    logic [4:0]        cnt;
    logic [24:0]       q;
    logic              sign_r, nan_r, bzero_r, azero_r;
    logic signed [9:0] ediff;

    logic              q_bit;
    logic [24:0]       rem_next;

    // Restoring step: subtract when it fits, then the caller shifts left.
    always_comb begin
        q_bit    = (rem >= {1'b0, dvsr});
        rem_next = q_bit ? (rem - {1'b0, dvsr}) : rem;
    end

    logic signed [9:0]   exp_n;
    logic [MANT_W-1:0]   mant_n;
    logic [31:0]         res_n;
    logic                dbz_n;

    always_comb begin
        if (q[24]) begin
            mant_n = q[23:1];
            exp_n  = ediff + BIAS_HI;
        end else begin
            mant_n = q[22:0];
            exp_n  = ediff + BIAS_LO;
        end
        dbz_n = 1'b0;
        if (nan_r) begin
            res_n = QNAN;
        end else if (bzero_r) begin
            dbz_n = 1'b1;
            res_n = azero_r ? QNAN : {sign_r, 8'hFF, 23'd0};
        end else if (azero_r) begin
            res_n = {sign_r, 31'd0};
        end else if (exp_n >= EXP_TOP) begin
            res_n = {sign_r, 8'hFF, 23'd0};
        end else if (exp_n <= 10'sd0) begin
            res_n = ZERO_ON_UNDERFLOW ? {sign_r, 31'd0} : {sign_r, 8'd1, 23'd0};
        end else begin
            res_n = {sign_r, exp_n[7:0], mant_n};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= 32'd0;
            div_by_zero <= 1'b0;
            rem         <= '0;
            dvsr        <= '0;
            cnt         <= '0;
            q           <= '0;
            sign_r      <= 1'b0;
            nan_r       <= 1'b0;
            bzero_r     <= 1'b0;
            azero_r     <= 1'b0;
            ediff       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        rem     <= {1'b0, a_mant};
                        dvsr    <= b_mant;
                        cnt     <= ITER_LAST;
                        q       <= '0;
                        sign_r  <= a_sign ^ b_sign;
                        nan_r   <= a_special | b_special;
                        bzero_r <= b_zero;
                        azero_r <= a_zero;
                        ediff   <= $signed({2'b00, a_exp}) - $signed({2'b00, b_exp});
                        busy    <= 1'b1;
                        state   <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    q   <= {q[23:0], q_bit};
                    rem <= rem_next << 1;
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd0) begin
                        state <= NORM;
                    end
                end
                NORM: begin
                    result      <= res_n;
                    div_by_zero <= dbz_n;
                    done        <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
